// File: rtl/wb_data_master.sv
// wb_data_master: single-access Wishbone classic master for a CPU load/store
// port. Handles byte/halfword/word lane steering, load extension,
// misalignment rejection and a bus wait timeout.
module wb_data_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    // Last wait-count value before the timeout fires (counter starts at 0).
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_lane;
    logic [31:0] r_adr;
    logic [3:0]  r_sel;
    logic [31:0] r_dat;
    logic [7:0]  r_wait;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_timeout;
    logic        w_term;
    logic [3:0]  w_sel;
    logic [31:0] w_dat;
    logic [31:0] w_lane;
    logic [31:0] w_load;

    assign w_accept  = (r_state == S_IDLE) && req_i;
    assign w_timeout = (r_wait == LP_LAST);
    assign w_term    = ack_i || err_i || w_timeout;

    assign adr_o   = r_adr;
    assign sel_o   = r_sel;
    assign dat_o   = r_dat;
    assign rdata_o = r_rdata;

    // Decode the incoming request: alignment check, lane selects, replicated store data.
    always_comb begin
        w_misaligned = 1'b0;
        w_sel        = 4'b0000;
        w_dat        = wdata_i;
        case (size_i)
            2'b00: begin
                w_sel = 4'b0001 << addr_i[1:0];
                w_dat = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_misaligned = addr_i[0];
                w_sel        = addr_i[1] ? 4'b1100 : 4'b0011;
                w_dat        = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                w_misaligned = (addr_i[1:0] != 2'b00);
                w_sel        = 4'b1111;
            end
            default: w_misaligned = 1'b1;
        endcase
    end

    // Move the addressed lane of the read data down to bit 0 and extend it.
    always_comb begin
        w_lane = dat_i >> {r_lane, 3'b000};
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_load = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
            default: w_load = dat_i;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and bus/handshake outputs.
    always_comb begin
        w_next = r_state;
        busy_o = 1'b0;
        cyc_o  = 1'b0;
        stb_o  = 1'b0;
        we_o   = 1'b0;
        done_o = 1'b0;
        err_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_i) w_next = w_misaligned ? S_RESP : S_BUS;
            end
            S_BUS: begin
                busy_o = 1'b1;
                cyc_o  = 1'b1;
                stb_o  = 1'b1;
                we_o   = r_we;
                if (w_term) w_next = S_RESP;
            end
            S_RESP: begin
                busy_o = 1'b1;
                done_o = 1'b1;
                err_o  = r_err;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch, wait counter and outcome capture (err beats ack, ack beats timeout).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_lane   <= 2'b00;
            r_adr    <= 32'h0;
            r_sel    <= 4'h0;
            r_dat    <= 32'h0;
            r_wait   <= 8'h0;
            r_err    <= 1'b0;
            r_rdata  <= 32'h0;
        end else if (w_accept) begin
            r_we     <= we_i;
            r_size   <= size_i;
            r_signed <= signed_i;
            r_lane   <= addr_i[1:0];
            r_adr    <= {addr_i[31:2], 2'b00};
            r_sel    <= w_sel;
            r_dat    <= w_dat;
            r_wait   <= 8'h0;
            if (w_misaligned) begin
                r_err   <= 1'b1;
                r_rdata <= 32'h0;
            end
        end else if (r_state == S_BUS) begin
            if (err_i) begin
                r_err   <= 1'b1;
                r_rdata <= 32'h0;
            end else if (ack_i) begin
                r_err   <= 1'b0;
                r_rdata <= r_we ? 32'h0 : w_load;
            end else if (w_timeout) begin
                r_err   <= 1'b1;
                r_rdata <= 32'h0;
            end else begin
                r_wait  <= r_wait + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_data_master.sv
// Testbench for wb_data_master: directed vector table, randomized accesses
// against a reference model, and hand-written reset/handshake sequences.
module tb_wb_data_master;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic        signed_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        busy_o, done_o, err_o, cyc_o, stb_o, we_o;
    logic [31:0] rdata_o, adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i = 32'h0;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    wb_data_master #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
        .size_i(size_i), .signed_i(signed_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .sel_o(sel_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
    );

    always #5 clk_i = ~clk_i;

    // term: 0 = never terminate (timeout), 1 = ack, 2 = err, 3 = ack+err together
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdat;
        int          k;
        logic [1:0]  term;
        logic        mis;
        logic [3:0]  exp_sel;
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdat, input int k, input logic [1:0] term,
                                input logic mis, input logic [3:0] sel, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [31:0] rdata, input logic err);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.rdat = rdat; v.k = k; v.term = term; v.mis = mis; v.exp_sel = sel;
        v.exp_adr = adr; v.exp_dat = dat; v.exp_rdata = rdata; v.exp_err = err;
        return v;
    endfunction

    // Reference model: derives the expected bus view and result from access rules.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          nb;
        int          sh;
        logic [31:0] mask;
        logic [31:0] lane;
        r  = v;
        sh = int'(v.addr % 4);
        nb = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        r.mis     = (v.size == 2'd3) || ((v.addr % nb) != 0);
        r.exp_adr = v.addr - 32'(sh);
        r.exp_sel = 4'(((1 << nb) - 1) << sh);
        if (nb == 1)      r.exp_dat = 32'(v.wdata[7:0]) * 32'h01010101;
        else if (nb == 2) r.exp_dat = 32'(v.wdata[15:0]) * 32'h00010001;
        else              r.exp_dat = v.wdata;
        r.exp_err = r.mis || (v.term != 2'd1);
        if (r.exp_err || v.we) begin
            r.exp_rdata = 32'h0;
        end else begin
            mask = (nb == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nb)) - 32'd1);
            lane = (v.rdat >> (8 * sh)) & mask;
            if (v.sgn && nb < 4 && lane >= (32'd1 << (8 * nb - 1)))
                lane = lane - (32'd1 << (8 * nb));
            r.exp_rdata = lane;
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string nm);
        int cyc;
        int exp_lat;
        req_i = 1'b1; we_i = v.we; size_i = v.size; signed_i = v.sgn;
        addr_i = v.addr; wdata_i = v.wdata;
        step();
        // scramble inputs: the access must run from latched values
        req_i = 1'b0; we_i = ~v.we; size_i = 2'(~v.size); signed_i = ~v.sgn;
        addr_i = $urandom; wdata_i = $urandom;
        chk({nm, ".busy"}, 32'(busy_o), 32'd1);
        cyc = 0;
        if (v.mis) begin
            exp_lat = 0;
            chk({nm, ".nocyc"}, 32'(cyc_o), 32'd0);
        end else begin
            exp_lat = (v.term == 2'd0) ? TO : v.k;
            while (cyc < TO + 2) begin
                cyc++;
                chk({nm, ".cyc"}, 32'({cyc_o, stb_o}), 32'd3);
                chk({nm, ".done0"}, 32'(done_o), 32'd0);
                if (cyc == 1) begin
                    chk({nm, ".adr"}, adr_o, v.exp_adr);
                    chk({nm, ".sel"}, 32'(sel_o), 32'(v.exp_sel));
                    chk({nm, ".dat"}, dat_o, v.exp_dat);
                    chk({nm, ".we"}, 32'(we_o), 32'(v.we));
                end
                if (v.term != 2'd0 && cyc == v.k) begin
                    ack_i = v.term[0]; err_i = v.term[1]; dat_i = v.rdat;
                end else begin
                    dat_i = $urandom;
                end
                step();
                ack_i = 1'b0; err_i = 1'b0; dat_i = $urandom;
                if (done_o) break;
            end
        end
        chk({nm, ".lat"}, 32'(cyc), 32'(exp_lat));
        chk({nm, ".done"}, 32'(done_o), 32'd1);
        chk({nm, ".err"}, 32'(err_o), 32'(v.exp_err));
        chk({nm, ".rdata"}, rdata_o, v.exp_rdata);
        chk({nm, ".cycresp"}, 32'({cyc_o, stb_o}), 32'd0);
        step();
        chk({nm, ".idle"}, 32'({busy_o, done_o}), 32'd0);
    endtask

    vec_t tbl[15];

    initial begin
        vec_t v;
        int   seen;
        tbl[0]  = mk(0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 2'd1, 0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        tbl[1]  = mk(0, 2'd0, 1, 32'h103, 32'h0, 32'h80112233, 1, 2'd1, 0, 4'h8, 32'h100, 32'h0, 32'hFFFFFF80, 0);
        tbl[2]  = mk(0, 2'd0, 0, 32'h103, 32'h0, 32'h80112233, 2, 2'd1, 0, 4'h8, 32'h100, 32'h0, 32'h00000080, 0);
        tbl[3]  = mk(1, 2'd1, 0, 32'h22, 32'h0000ABCD, 32'h0, 2, 2'd1, 0, 4'hC, 32'h20, 32'hABCDABCD, 32'h0, 0);
        tbl[4]  = mk(0, 2'd2, 0, 32'h02, 32'h0, 32'h0, 1, 2'd1, 1, 4'h0, 32'h0, 32'h0, 32'h0, 1);
        tbl[5]  = mk(0, 2'd3, 0, 32'h100, 32'h0, 32'h0, 1, 2'd1, 1, 4'h0, 32'h0, 32'h0, 32'h0, 1);
        tbl[6]  = mk(0, 2'd1, 1, 32'h101, 32'h0, 32'h0, 1, 2'd1, 1, 4'h0, 32'h0, 32'h0, 32'h0, 1);
        tbl[7]  = mk(0, 2'd2, 0, 32'h200, 32'h0, 32'h11111111, 1, 2'd0, 0, 4'hF, 32'h200, 32'h0, 32'h0, 1);
        tbl[8]  = mk(0, 2'd2, 0, 32'h300, 32'h0, 32'h12345678, 1, 2'd3, 0, 4'hF, 32'h300, 32'h0, 32'h0, 1);
        tbl[9]  = mk(1, 2'd0, 0, 32'h41, 32'h5A, 32'h0, 3, 2'd2, 0, 4'h2, 32'h40, 32'h5A5A5A5A, 32'h0, 1);
        tbl[10] = mk(0, 2'd1, 1, 32'h102, 32'h0, 32'h80011234, 2, 2'd1, 0, 4'hC, 32'h100, 32'h0, 32'hFFFF8001, 0);
        tbl[11] = mk(0, 2'd0, 1, 32'h102, 32'h0, 32'h007F0000, 1, 2'd1, 0, 4'h4, 32'h100, 32'h0, 32'h0000007F, 0);
        tbl[12] = mk(0, 2'd2, 0, 32'h300, 32'h0, 32'h12345678, 4, 2'd1, 0, 4'hF, 32'h300, 32'h0, 32'h12345678, 0);
        tbl[13] = mk(1, 2'd2, 0, 32'h44, 32'hCAFEF00D, 32'h0, 3, 2'd1, 0, 4'hF, 32'h44, 32'hCAFEF00D, 32'h0, 0);
        tbl[14] = mk(0, 2'd1, 0, 32'h100, 32'h0, 32'h8001FFEE, 1, 2'd1, 0, 4'h3, 32'h100, 32'h0, 32'h0000FFEE, 0);

        // reset state
        step(); step();
        chk("rst.ctl", 32'({busy_o, done_o, err_o, cyc_o, stb_o, we_o}), 32'd0);
        chk("rst.adr", adr_o, 32'h0);
        chk("rst.sel", 32'(sel_o), 32'h0);
        chk("rst.dat", dat_o, 32'h0);
        chk("rst.rdata", rdata_o, 32'h0);
        rst_i = 1'b0;
        step();

        // terminations outside BUS are ignored
        ack_i = 1'b1; err_i = 1'b1;
        step(); step();
        chk("idle.ackerr", 32'({busy_o, done_o, err_o, cyc_o}), 32'd0);
        ack_i = 1'b0; err_i = 1'b0;

        // directed vectors
        for (int i = 0; i < 15; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // randomized accesses against the model
        for (int i = 0; i < 60; i++) begin
            int t;
            v.we    = 1'($urandom);
            v.size  = 2'($urandom_range(0, 3));
            v.sgn   = 1'($urandom);
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdat  = $urandom;
            v.k     = $urandom_range(1, TO);
            t = $urandom_range(0, 9);
            v.term  = (t == 0) ? 2'd0 : (t == 1) ? 2'd2 : (t == 2) ? 2'd3 : 2'd1;
            if ($urandom_range(0, 3) != 0 && v.size != 2'd3)
                v.addr[1:0] = (v.size == 2'd2) ? 2'b00 : (v.size == 2'd1) ? {v.addr[1], 1'b0} : v.addr[1:0];
            run_txn(model(v), $sformatf("rnd%0d", i));
        end

        // request held high is re-accepted right after RESP
        req_i = 1'b1; size_i = 2'd3; we_i = 1'b0; addr_i = 32'h0;
        step();
        chk("hold.resp1", 32'({busy_o, done_o}), 32'd3);
        step();
        chk("hold.idle", 32'(busy_o), 32'd0);
        step();
        chk("hold.resp2", 32'({busy_o, done_o}), 32'd3);
        req_i = 1'b0;
        step();
        chk("hold.end", 32'(busy_o), 32'd0);

        // reset during BUS aborts with no completion
        req_i = 1'b1; size_i = 2'd2; we_i = 1'b1; addr_i = 32'h80; wdata_i = 32'h55AA55AA;
        step();
        req_i = 1'b0;
        chk("rbus.cyc", 32'(cyc_o), 32'd1);
        rst_i = 1'b1;
        step();
        chk("rbus.drop", 32'({cyc_o, stb_o, busy_o, we_o}), 32'd0);
        chk("rbus.adr", adr_o, 32'h0);
        rst_i = 1'b0;
        seen = 0;
        ack_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (done_o || busy_o) seen++;
            step();
        end
        ack_i = 1'b0;
        chk("rbus.nodone", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/wb_data_master.md
WB_DATA_MASTER -- requirements
Module: wb_data_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, the number of Wishbone cycles to wait for ack_i/err_i before aborting (legal range 1..255).
REQ-002 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 req_i  in  1  CPU access request; sampled only in IDLE.
REQ-005 we_i  in  1  1 = store, 0 = load.
REQ-006 size_i  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-007 signed_i  in  1  1 = sign-extend load data, 0 = zero-extend.
REQ-008 addr_i  in  32  CPU byte address.
REQ-009 wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 busy_o  out  1  high whenever state is not IDLE.
REQ-011 done_o  out  1  one-cycle completion pulse.
REQ-012 err_o  out  1  error status, valid with done_o.
REQ-013 rdata_o  out  32  extended load data, valid with done_o.
REQ-014 cyc_o, stb_o  out  1 each  Wishbone classic cycle and strobe.
REQ-015 we_o  out  1  Wishbone write enable.
REQ-016 adr_o  out  32  Wishbone address, always word-aligned ([1:0] = 00).
REQ-017 sel_o  out  4  Wishbone byte lane selects.
REQ-018 dat_o  out  32  Wishbone write data.
REQ-019 dat_i  in  32  Wishbone read data.
REQ-020 ack_i, err_i  in  1 each  Wishbone termination inputs.

Function
REQ-021 The FSM SHALL have the states IDLE, BUS and RESP.
REQ-022 In IDLE with req_i=1, the block SHALL latch we_i, size_i, signed_i, addr_i and wdata_i.
REQ-023 On that acceptance, the block SHALL move to RESP if the access is misaligned, and to BUS otherwise.
REQ-024 Misaligned means: size 11; halfword with addr[0]=1; or word with addr[1:0]!=00.
REQ-025 A misaligned access SHALL NOT assert cyc_o.
REQ-026 In BUS, cyc_o and stb_o SHALL be high, starting the cycle after acceptance.
REQ-027 In BUS, adr_o SHALL be {addr[31:2],2'b00} and we_o SHALL equal the latched we.
REQ-028 sel_o SHALL be: byte -> 0001 shifted left by addr[1:0]; half -> 0011 if addr[1]=0, else 1100; word -> 1111.
REQ-029 dat_o SHALL replicate the store data across lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-030 In BUS, ack_i=1 SHALL capture dat_i and move to RESP with error clear.
REQ-031 In BUS, err_i=1 SHALL move to RESP with error set.
REQ-032 If ack_i and err_i are both 1 in the same cycle, err SHALL win.
REQ-033 A wait counter SHALL clear on entry to BUS and increment each BUS cycle without termination.
REQ-034 When the wait counter reaches TIMEOUT, the block SHALL move to RESP with error set.
REQ-035 cyc_o and stb_o SHALL be low in RESP and IDLE; the cycle always ends the edge after termination.
REQ-036 RESP SHALL last exactly one cycle: done_o=1, err_o per the outcome, then return to IDLE.
REQ-037 In RESP for a load, rdata_o SHALL hold the selected lane shifted to bit 0, then sign- or zero-extended per signed_i.
REQ-038 For stores or errors, rdata_o SHALL be 0.
REQ-039 Latency: with ack at BUS cycle k (k = 1 is the first BUS cycle), done_o SHALL assert k+1 cycles after acceptance; a misaligned access completes at +1.
REQ-040 req_i SHALL be ignored while busy_o=1; a request held high is re-accepted in the first IDLE cycle after RESP.
REQ-041 ack_i and err_i SHALL be ignored outside BUS.
REQ-042 dat_i SHALL be sampled only on the terminating ack.

Reset
REQ-043 While rst_i=1 at a clock edge, the state SHALL become IDLE.
REQ-044 Reset SHALL clear cyc_o, stb_o, we_o, done_o, err_o and busy_o, and set adr_o, sel_o, dat_o and rdata_o to 0.
REQ-045 Reset during BUS SHALL drop cyc_o/stb_o at that edge and SHALL produce no done_o for the aborted access.

Verification
REQ-046 Word load at addr 0x100 with ack on the first BUS cycle, dat_i=0xDEADBEEF -> adr_o=0x100, sel_o=1111, done_o at +2, rdata_o=0xDEADBEEF, err_o=0.
REQ-047 Signed byte load at addr 0x103, dat_i=0x80112233 -> sel_o=1000, rdata_o=0xFFFFFF80; the same load unsigned -> rdata_o=0x00000080.
REQ-048 Halfword store at addr 0x22, wdata=0x0000ABCD -> adr_o=0x20, sel_o=1100, dat_o=0xABCDABCD, we_o=1.
REQ-049 Word load at addr 0x02 -> no cyc_o, done_o=1 and err_o=1 at +1; size 11 -> same result.
REQ-050 TIMEOUT=4 and no ack -> cyc_o high for 4 cycles, then done_o=1, err_o=1.
REQ-051 ack_i and err_i asserted together -> err_o=1; rst_i asserted during BUS -> cyc_o=0 next edge and no done_o.
